// File: rtl/tpu_sequencer.sv
// tpu_sequencer: Moore FSM driving one weight-tile job (FIFO pop, reload, UB streaming, result writeback); ports: clk/rst, start+num_rows/ub_base/res_base job request, fifo_empty in, fifo/we_rl/UB/result strobes and addresses, busy, end_ out
module tpu_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int LATENCY = 129
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] num_rows,
  input  logic [ADDRESSSIZE-1:0] ub_base,
  input  logic [ADDRESSSIZE-1:0] res_base,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic                   ub_read_valid,
  output logic [ADDRESSSIZE-1:0] ub_address,
  output logic                   res_write_enable,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   busy,
  output logic                   end_
);
  localparam int TW = $clog2((1 << ADDRESSSIZE) + LATENCY);
  localparam logic [TW-1:0] LAT = TW'(LATENCY);
  typedef enum logic [2:0] {IDLE, WAIT_W, FETCH, RELOAD, STREAM, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [ADDRESSSIZE-1:0] n_q, n_d, ub_base_q, ub_base_d, res_base_q, res_base_d;
  logic [ADDRESSSIZE-1:0] ub_address_q, ub_address_d, res_address_q, res_address_d;
  logic fifo_read_enable_q, fifo_read_enable_d, we_rl_q, we_rl_d;
  logic ub_read_valid_q, ub_read_valid_d, res_write_enable_q, res_write_enable_d;
  logic busy_q, busy_d, end_q, end_d, run_d;
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    n_d = n_q;
    ub_base_d = ub_base_q;
    res_base_d = res_base_q;
    case (state_q)
      IDLE: if (start) begin
        n_d = num_rows;
        ub_base_d = ub_base;
        res_base_d = res_base;
        state_d = num_rows != '0 ? WAIT_W : DONE;
      end
      WAIT_W: state_d = fifo_empty ? WAIT_W : FETCH;
      FETCH: state_d = RELOAD;
      RELOAD: begin
        state_d = STREAM;
        t_d = '0;
      end
      STREAM: begin
        t_d = t_q + 1'b1;
        state_d = t_q == TW'(n_q) - 1'b1 ? DRAIN : STREAM;
      end
      DRAIN: begin
        t_d = t_q + 1'b1;
        state_d = t_q == LAT + TW'(n_q) - 1'b1 ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are precomputed from the next state so every output is a flop.
    run_d = state_d == STREAM || state_d == DRAIN;
    ub_read_valid_d = run_d && t_d < TW'(n_d);
    res_write_enable_d = run_d && t_d >= LAT && t_d < LAT + TW'(n_d);
    ub_address_d = ub_read_valid_d ? ub_base_d + ADDRESSSIZE'(t_d) : ub_address_q;
    res_address_d = res_write_enable_d ? res_base_d + ADDRESSSIZE'(t_d - LAT) : res_address_q;
    fifo_read_enable_d = state_d == FETCH;
    we_rl_d = state_d == RELOAD;
    busy_d = state_d != IDLE;
    end_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q <= '0;
      n_q <= '0;
      ub_base_q <= '0;
      res_base_q <= '0;
      ub_address_q <= '0;
      res_address_q <= '0;
      fifo_read_enable_q <= 1'b0;
      we_rl_q <= 1'b0;
      ub_read_valid_q <= 1'b0;
      res_write_enable_q <= 1'b0;
      busy_q <= 1'b0;
      end_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      n_q <= n_d;
      ub_base_q <= ub_base_d;
      res_base_q <= res_base_d;
      ub_address_q <= ub_address_d;
      res_address_q <= res_address_d;
      fifo_read_enable_q <= fifo_read_enable_d;
      we_rl_q <= we_rl_d;
      ub_read_valid_q <= ub_read_valid_d;
      res_write_enable_q <= res_write_enable_d;
      busy_q <= busy_d;
      end_q <= end_d;
    end
  end
  assign fifo_read_enable = fifo_read_enable_q;
  assign we_rl = we_rl_q;
  assign ub_read_valid = ub_read_valid_q;
  assign ub_address = ub_address_q;
  assign res_write_enable = res_write_enable_q;
  assign res_address = res_address_q;
  assign busy = busy_q;
  assign end_ = end_q;
endmodule

// File: tb/tb_tpu_sequencer.sv
// tb_tpu_sequencer: directed checks of tpu_sequencer at LATENCY=129 and LATENCY=4
module tb_tpu_sequencer;
  logic clk = 1'b0;
  logic rst, start_a, start_b, fifo_empty;
  logic [9:0] num_rows, ub_base, res_base;
  logic fre_a, werl_a, rv_a, wv_a, busy_a, end_a;
  logic fre_b, werl_b, rv_b, wv_b, busy_b, end_b;
  logic [9:0] ua_a, ra_a, ua_b, ra_b;
  int n_chk = 0;
  int n_pass = 0;
  int last_ub[2];
  int last_res[2];
  always #5 clk = ~clk;
  tpu_sequencer u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_rows(num_rows), .ub_base(ub_base),
    .res_base(res_base), .fifo_empty(fifo_empty), .fifo_read_enable(fre_a), .we_rl(werl_a),
    .ub_read_valid(rv_a), .ub_address(ua_a), .res_write_enable(wv_a), .res_address(ra_a),
    .busy(busy_a), .end_(end_a)
  );
  tpu_sequencer #(.ADDRESSSIZE(10), .LATENCY(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_rows(num_rows), .ub_base(ub_base),
    .res_base(res_base), .fifo_empty(fifo_empty), .fifo_read_enable(fre_b), .we_rl(werl_b),
    .ub_read_valid(rv_b), .ub_address(ua_b), .res_write_enable(wv_b), .res_address(ra_b),
    .busy(busy_b), .end_(end_b)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Cycle 0 is the cycle start is presented; job timeline is fixed by lat, stall and n.
  task automatic run_job(input bit b, input int n, input int ub, input int res, input int stall, input bit hold);
    int lat, rs, ws, done;
    bit erv, ewv;
    lat = b ? 4 : 129;
    rs = 4 + stall;
    ws = rs + lat;
    done = n == 0 ? 1 : ws + n;
    num_rows = 10'(n);
    ub_base = 10'(ub);
    res_base = 10'(res);
    fifo_empty = stall > 0;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    for (int c = 1; c <= done + 1; c++) begin
      tick();
      if (c == 1 && !hold) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (c == stall + 1) fifo_empty = 1'b0;
      if (c == stall + 3) fifo_empty = 1'b1;
      erv = n > 0 && c >= rs && c < rs + n;
      ewv = n > 0 && c >= ws && c < ws + n;
      if (erv) last_ub[b] = (ub + c - rs) % 1024;
      if (ewv) last_res[b] = (res + c - ws) % 1024;
      check($sformatf("fifo_re n%0d c%0d", n, c), b ? fre_b : fre_a, int'(n > 0 && c == stall + 2));
      check($sformatf("we_rl n%0d c%0d", n, c), b ? werl_b : werl_a, int'(n > 0 && c == stall + 3));
      check($sformatf("ub_valid n%0d c%0d", n, c), b ? rv_b : rv_a, int'(erv));
      check($sformatf("ub_addr n%0d c%0d", n, c), b ? ua_b : ua_a, last_ub[b]);
      check($sformatf("res_we n%0d c%0d", n, c), b ? wv_b : wv_a, int'(ewv));
      check($sformatf("res_addr n%0d c%0d", n, c), b ? ra_b : ra_a, last_res[b]);
      check($sformatf("busy n%0d c%0d", n, c), b ? busy_b : busy_a, int'(c <= done));
      check($sformatf("end n%0d c%0d", n, c), b ? end_b : end_a, int'(c == done));
    end
  endtask
  initial begin
    rst = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    fifo_empty = 1'b0;
    num_rows = 10'd5;
    ub_base = 10'd1;
    res_base = 10'd2;
    last_ub = '{0, 0};
    last_res = '{0, 0};
    tick();
    tick();
    check("rst busy_a", busy_a, 0);
    check("rst busy_b", busy_b, 0);
    check("rst ub_addr", ua_a, 0);
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    tick();
    check("rst start ignored a", busy_a, 0);
    check("rst start ignored b", busy_b, 0);
    run_job(1'b0, 3, 10, 100, 0, 1'b0);
    run_job(1'b0, 3, 10, 100, 20, 1'b0);
    run_job(1'b0, 0, 50, 60, 0, 1'b0);
    run_job(1'b1, 8, 1020, 1022, 0, 1'b0);
    num_rows = 10'd3;
    ub_base = 10'd10;
    res_base = 10'd100;
    fifo_empty = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid t2 ub_valid", rv_a, 1);
    check("mid t2 ub_addr", ua_a, 12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_ub = '{0, 0};
    last_res = '{0, 0};
    check("mid rst fifo_re", fre_a, 0);
    check("mid rst we_rl", werl_a, 0);
    check("mid rst ub_valid", rv_a, 0);
    check("mid rst ub_addr", ua_a, 0);
    check("mid rst res_we", wv_a, 0);
    check("mid rst res_addr", ra_a, 0);
    check("mid rst busy", busy_a, 0);
    check("mid rst end", end_a, 0);
    check("mid rst busy_b", busy_b, 0);
    check("mid rst ub_addr_b", ua_b, 0);
    run_job(1'b0, 3, 10, 100, 0, 1'b0);
    run_job(1'b0, 2, 5, 7, 0, 1'b1);
    run_job(1'b0, 2, 5, 7, 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tpu_sequencer.md
TPU_SEQUENCER -- requirements
Module: tpu_sequencer

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, default 10: width of Unified Buffer (UB) and result SRAM addresses and of the row count.
REQ-002 SHALL have parameter LATENCY, default 129: cycles from a UB read to the matching result-SRAM write (input skew, array traversal, deskew).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-006 SHALL have port num_rows  input  ADDRESSSIZE  activation rows in the job; latched on accepted start.
REQ-007 SHALL have port ub_base  input  ADDRESSSIZE  first UB read address; latched on accepted start.
REQ-008 SHALL have port res_base  input  ADDRESSSIZE  first result write address; latched on accepted start.
REQ-009 SHALL have port fifo_empty  input  1  weight FIFO empty flag.
REQ-010 SHALL have port fifo_read_enable  output  1  one-cycle pop of one weight tile.
REQ-011 SHALL have port we_rl  output  1  one-cycle weight-reload strobe to the systolic array.
REQ-012 SHALL have port ub_read_valid  output  1  UB row read active this cycle.
REQ-013 SHALL have port ub_address  output  ADDRESSSIZE  UB read address.
REQ-014 SHALL have port res_write_enable  output  1  result SRAM write strobe.
REQ-015 SHALL have port res_address  output  ADDRESSSIZE  result SRAM write address.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port end_  output  1  one-cycle job-complete pulse.

Function
REQ-018 SHALL implement states IDLE, WAIT_W, FETCH, RELOAD, STREAM, DRAIN, DONE; all outputs are decoded from current state and registers (Moore), no combinational input-to-output path.
REQ-019 IDLE: start=1 latches num_rows/ub_base/res_base; next state WAIT_W if num_rows!=0, else DONE; start=0 stays in IDLE.
REQ-020 WAIT_W: stays while fifo_empty=1 (unbounded stall, no timeout); fifo_empty=0 -> FETCH.
REQ-021 FETCH: fifo_read_enable=1 for exactly this cycle; next state RELOAD.
REQ-022 RELOAD: we_rl=1 for exactly this cycle; next state STREAM; phase counter t cleared to 0.
REQ-023 t SHALL increment by 1 every cycle in STREAM and DRAIN; width sufficient for (2^ADDRESSSIZE-2)+LATENCY without overflow.
REQ-024 ub_read_valid=1 and ub_address=(ub_base+t) mod 2^ADDRESSSIZE for t in 0..N-1 (N = latched num_rows); otherwise ub_read_valid=0 and ub_address holds its last value.
REQ-025 STREAM -> DRAIN after the cycle with t=N-1.
REQ-026 res_write_enable=1 and res_address=(res_base+t-LATENCY) mod 2^ADDRESSSIZE for t in LATENCY..LATENCY+N-1, overlapping STREAM when N>LATENCY; otherwise res_write_enable=0 and res_address holds.
REQ-027 DRAIN -> DONE after the cycle with t=LATENCY+N-1.
REQ-028 DONE: end_=1 for this single cycle, busy=1; next state IDLE unconditionally.
REQ-029 start while busy=1 SHALL be ignored, with no queuing; start sampled in IDLE on the cycle after DONE begins a new job.
REQ-030 fifo_empty SHALL be ignored outside WAIT_W.
REQ-031 Exactly one fifo_read_enable pulse and one we_rl pulse per job with N>=1; none for N=0.
REQ-032 Address wrap: ub_base+t and res_base+t-LATENCY SHALL wrap modulo 2^ADDRESSSIZE without error.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, t=0, latched registers to 0, and all outputs to 0 (addresses 0) on the next cycle, from any state including mid-STREAM/DRAIN.
REQ-034 start asserted together with rst SHALL be ignored.

Verification
REQ-035 Basic job, LATENCY=129, fifo non-empty: start at cycle 0 with N=3, ub_base=10, res_base=100. Required: FETCH at cycle 2, we_rl at 3, UB reads 10,11,12 at 4-6, writes 100,101,102 at 133-135, end_ at 136, busy=0 at 137.
REQ-036 FIFO stall: fifo_empty=1 for 20 cycles after start. Required: no fifo_read_enable while empty; fifo_read_enable 1 cycle after fifo_empty falls; all later timing shifted by 20.
REQ-037 N=0: start. Required: next cycle DONE, end_=1 once; no fifo, we_rl, UB or result strobes.
REQ-038 Wrap/overlap: ADDRESSSIZE=10, LATENCY=4, N=8, ub_base=1020, res_base=1022. Required: UB reads 1020..1023,0..3; writes 1022,1023,0..5 starting at t=4, overlapping reads.
REQ-039 Reset mid-job: rst at t=2 of STREAM. Required: next cycle all outputs 0 and IDLE; a new start runs the REQ-035 sequence normally.
REQ-040 start held high through a whole job. Required: start ignored while busy; a second job begins on the cycle after end_.
